// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction word per req/ack handshake
// and presents it to decode until the consumer releases it.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jmp,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        req_r;
    logic        valid_r;
    logic [31:0] pcPlus4_s;
    logic [31:0] branchOff_s;
    logic [31:0] nextPc_s;

    assign pcPlus4_s   = pc_r + 32'd4;
    assign branchOff_s = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};

    // Next-PC select; jump outranks a taken branch
    always_comb begin
        nextPc_s = pcPlus4_s;
        if (jmp) begin
            nextPc_s = {pcPlus4_s[31:28], instr_r[25:0], 2'b00};
        end else if (branch_taken) begin
            nextPc_s = pcPlus4_s + branchOff_s;
        end else begin
            nextPc_s = pcPlus4_s;
        end
    end

    // Fetch FSM; imem_req is registered so it is high exactly for the REQ cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= REQ;
                    req_r   <= 1'b1;
                end
                REQ: begin
                    state_r <= WAIT;
                    req_r   <= 1'b0;
                end
                WAIT: begin
                    // Acks are only honoured here, so a stale response after reset is dropped
                    if (imem_ack) begin
                        instr_r <= imem_rdata;
                        valid_r <= 1'b1;
                        state_r <= ISSUE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_r    <= nextPc_s;
                        valid_r <= 1'b0;
                        req_r   <= 1'b1;
                        state_r <= REQ;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[31:26];
    assign funct       = instr_r[5:0];
    assign pc          = pc_r;
    assign pc_plus4    = pcPlus4_s;
    assign instr_valid = valid_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table of fetches plus reset,
// wrap-around and reset-abort sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jmp = 1'b0;

    logic        imem_req, w_imem_req;
    logic [31:0] imem_addr, w_imem_addr;
    logic [31:0] instr, w_instr;
    logic [5:0]  opcode, w_opcode;
    logic [5:0]  funct, w_funct;
    logic [31:0] pc, w_pc;
    logic [31:0] pc_plus4, w_pc_plus4;
    logic        instr_valid, w_instr_valid;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .jmp(jmp), .instr(instr), .opcode(opcode),
        .funct(funct), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .jmp(jmp), .instr(w_instr), .opcode(w_opcode),
        .funct(w_funct), .pc(w_pc), .pc_plus4(w_pc_plus4), .instr_valid(w_instr_valid)
    );

    typedef struct {
        logic [31:0] rdata;
        int          ackDelay;
        int          stallCyc;
        logic        br;
        logic        jp;
        logic [31:0] expPc;
        logic [5:0]  expOpc;
        logic [5:0]  expFn;
        logic [31:0] expNext;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, {31'd0, imem_req}, 32'd1);
    endtask

    // One complete fetch; expects to start at or before the REQ cycle
    task automatic doFetch(input vec_t v, input string name);
        waitReq(name);
        check({name, "_addr"}, imem_addr, v.expPc);
        check({name, "_valid_in_req"}, {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < v.ackDelay; k++) begin
            check({name, "_noreq_wait"}, {31'd0, imem_req}, 32'd0);
            check({name, "_novalid_wait"}, {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        imem_ack = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({name, "_instr"}, instr, v.rdata);
        check({name, "_opcode"}, {26'd0, opcode}, {26'd0, v.expOpc});
        check({name, "_funct"}, {26'd0, funct}, {26'd0, v.expFn});
        check({name, "_pc"}, pc, v.expPc);
        check({name, "_pc_plus4"}, pc_plus4, v.expPc + 32'd4);
        for (int k = 0; k < v.stallCyc; k++) begin
            stall = 1'b1;
            branch_taken = ~v.br;
            jmp = ~v.jp;
            @(negedge clk);
            check({name, "_noreq_stall"}, {31'd0, imem_req}, 32'd0);
            check({name, "_hold_valid"}, {31'd0, instr_valid}, 32'd1);
            check({name, "_hold_instr"}, instr, v.rdata);
            check({name, "_hold_pc"}, pc, v.expPc);
        end
        stall = 1'b0;
        branch_taken = v.br;
        jmp = v.jp;
        @(negedge clk);
        branch_taken = 1'b0;
        jmp = 1'b0;
        check({name, "_next_req"}, {31'd0, imem_req}, 32'd1);
        check({name, "_next_addr"}, imem_addr, v.expNext);
        check({name, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        //          rdata          dly stl br  jp   pc             opc    fn     next
        vecs[0] = '{32'h8C08_0004, 0, 0, 1'b0, 1'b0, 32'h0040_0000, 6'h23, 6'h04, 32'h0040_0004};
        vecs[1] = '{32'h0109_5020, 4, 3, 1'b0, 1'b0, 32'h0040_0004, 6'h00, 6'h20, 32'h0040_0008};
        vecs[2] = '{32'h1100_FFFF, 0, 0, 1'b1, 1'b0, 32'h0040_0008, 6'h04, 6'h3F, 32'h0040_0008};
        vecs[3] = '{32'h1100_FFFF, 1, 0, 1'b0, 1'b0, 32'h0040_0008, 6'h04, 6'h3F, 32'h0040_000C};
        vecs[4] = '{32'h0810_0010, 0, 1, 1'b1, 1'b1, 32'h0040_000C, 6'h02, 6'h10, 32'h0040_0040};
        vecs[5] = '{32'h1000_0003, 2, 0, 1'b1, 1'b0, 32'h0040_0040, 6'h04, 6'h03, 32'h0040_0050};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0040_0000);
        check("rst_pc_plus4", pc_plus4, 32'h0040_0004);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_funct", {26'd0, funct}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("wrap_rst_pc_plus4", w_pc_plus4, 32'h0000_0000);

        // One IDLE cycle after release, then a single-cycle request
        rst_n = 1'b1;
        #1;
        check("idle_no_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0040_0000);

        for (int i = 0; i < 6; i++) begin
            doFetch(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                check("wrap_next_addr", w_imem_addr, 32'h0000_0000);
                check("wrap_next_req", {31'd0, w_imem_req}, 32'd1);
            end
        end

        // Reset during WAIT, then a late ack in IDLE/REQ must be ignored
        @(negedge clk);
        check("abort_in_wait", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_instr_clr", instr, 32'h0);
        check("abort_pc", pc, 32'h0040_0000);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("abort_instr_idle", instr, 32'h0);
        check("abort_restart_req", {31'd0, imem_req}, 32'd1);
        check("abort_restart_addr", imem_addr, 32'h0040_0000);
        imem_ack = 1'b0;
        @(negedge clk);
        check("abort_instr_req", instr, 32'h0);
        check("abort_valid", {31'd0, instr_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the single-cycle MIPS processor. Holds the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake. Presents the captured instruction, with its opcode and funct fields, to the control unit and datapath. Selects the next PC from sequential, branch or jump targets once the consuming stage releases the instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request strobe, exactly one cycle per fetch
- imem_addr  out  32  byte address of fetch; valid while imem_req=1
- imem_ack  in  1  instruction memory response valid
- imem_rdata  in  32  instruction word; valid while imem_ack=1
- stall  in  1  consumer not ready; hold the issued instruction
- branch_taken  in  1  Branch AND ALU-zero from the datapath; sampled in ISSUE
- jmp  in  1  jump decode from the control unit; sampled in ISSUE
- instr  out  32  captured instruction word
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- pc  out  32  address of instr
- pc_plus4  out  32  pc + 4
- instr_valid  out  1  instr/opcode/funct/pc valid for the consumer

## Operation
- States: IDLE, REQ, WAIT, ISSUE.
- IDLE: entered on reset. Moves to REQ unconditionally on the next clock.
- REQ: imem_req=1, imem_addr=pc. Moves to WAIT. imem_ack is ignored in REQ.
- WAIT: imem_req=0. When imem_ack=1, instr<=imem_rdata and the FSM moves to ISSUE. With imem_ack=0 it stays in WAIT indefinitely; there is no timeout.
- ISSUE: instr_valid=1.
  - stall=1: instr, pc and instr_valid hold; no request is issued.
  - stall=0: pc<=next_pc and the FSM moves to REQ.
- next_pc priority, evaluated in ISSUE with stall=0:
  - jmp=1 selects {pc_plus4[31:28], instr[25:0], 2'b00}. jmp takes priority over branch_taken.
  - else branch_taken=1 selects pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - else pc_plus4.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32 and wraps silently, e.g. 0xFFFFFFFC+4 = 0x00000000. Bits [1:0] of pc are always 00 by construction.
- opcode and funct are continuous slices of instr. pc_plus4 is combinational from pc.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
  - imem_addr=RESET_PC, opcode=0, funct=0, pc_plus4=RESET_PC+4.
- Reset release: IDLE for 1 cycle, then REQ.
- Minimum fetch period is 3 cycles (REQ, WAIT with ack, ISSUE). Each cycle of ack delay and each stall cycle adds one cycle.
- instr_valid rises on the clock edge that captures imem_rdata. It falls on the edge leaving ISSUE.
- branch_taken and jmp are don't-care outside ISSUE and while stall=1.
- Reset mid-operation: any outstanding fetch is abandoned. An imem_ack arriving in IDLE or REQ is ignored and must not update instr.
- Only one request is ever outstanding.

## Test plan
- Reset: RESET_PC=0x00400000, release rst_n. One IDLE cycle, then imem_req=1 for exactly one cycle with imem_addr=0x00400000; instr_valid=0 throughout.
- Sequential fetch:
  - Stimulus: ack one cycle after req with rdata=0x8C080004.
  - Required: instr_valid=1, opcode=0x23, funct=0x04, pc=0x00400000, pc_plus4=0x00400004.
  - With stall=0, the next imem_addr is 0x00400004.
- Branch:
  - Stimulus: instr 0x1100FFFF (beq, imm=-1) at pc=0x00400008 with branch_taken=1. Required: next imem_addr=0x00400008.
  - Stimulus: same instruction with branch_taken=0. Required: next imem_addr=0x0040000C.
- Jump priority:
  - Stimulus: instr 0x08100010 at pc=0x0040000C with jmp=1 and branch_taken=1.
  - Required: next imem_addr=0x00400040.
- Stall and slow memory:
  - Stimulus: ack delayed 4 cycles in WAIT, then stall=1 held for 3 cycles in ISSUE.
  - Required: no imem_req while waiting or stalled; instr, pc and instr_valid stable during stall; exactly one imem_req after stall drops.
- Wrap and reset abort:
  - Stimulus: RESET_PC=0xFFFFFFFC with a sequential instruction. Required: next imem_addr=0x00000000.
  - Stimulus: assert rst_n=0 during WAIT, release it, then drive a late imem_ack in IDLE. Required: instr remains 0 and the fetch restarts at RESET_PC.
